// File: rtl/pcie_phys_pkg.sv
// pcie_phys_pkg: types and helpers shared by the PCIe PHY control blocks.
// Holds the receiver-detect state encoding, the link generation encoding and
// the power-of-two lane-prefix width rule also needed by the LTSSM.
package pcie_phys_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_QUIET  = 3'd1,
    ST_CHARGE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EVAL   = 3'd4,
    ST_DONE   = 3'd5
  } rx_detect_state_e;

  typedef enum logic [1:0] {
    GEN1 = 2'd1,
    GEN2 = 2'd2,
    GEN3 = 2'd3
  } link_gen_e;

  // Widest link any PHY in this family supports.
  localparam int unsigned MAX_LANES  = 16;
  localparam int unsigned WIDTH_BITS = 5;

  // Largest power of two k <= num_lanes such that lanes 0..k-1 are all set;
  // 0 when lane 0 is clear.
  function automatic logic [WIDTH_BITS-1:0] width_from_mask(
    input logic [MAX_LANES-1:0] mask,
    input int unsigned          num_lanes
  );
    logic                  prefix_ok;
    logic [WIDTH_BITS-1:0] width;
    prefix_ok = 1'b1;
    width     = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < num_lanes) begin
        prefix_ok = prefix_ok & mask[i];
        if (prefix_ok && (((i + 1) & i) == 0)) begin
          width = WIDTH_BITS'(i + 1);
        end
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/pcie_lane_debounce.sv
// pcie_lane_debounce: per-lane saturating run counter for receiver detect.
// A lane is qualified once it has been sampled high DETECT_CYCLES times in a
// row; any low sample drops it back to zero.
module pcie_lane_debounce #(
  parameter int unsigned DETECT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic load_detect_i,
  output logic qualified_o
);

  localparam int unsigned       CW     = $clog2(DETECT_CYCLES + 1);
  localparam logic [CW-1:0]     SAT    = CW'(DETECT_CYCLES);
  localparam logic [CW-1:0]     SAT_M1 = CW'(DETECT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_qual;

  // Count consecutive high samples, saturate at DETECT_CYCLES, flag on saturation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_qual <= 1'b0;
    end else if (clr_i) begin
      r_cnt  <= '0;
      r_qual <= 1'b0;
    end else if (en_i) begin
      if (!load_detect_i) begin
        r_cnt  <= '0;
        r_qual <= 1'b0;
      end else if (r_cnt != SAT) begin
        r_cnt  <= r_cnt + CW'(1);
        r_qual <= (r_cnt == SAT_M1);
      end else begin
        r_qual <= 1'b1;
      end
    end
  end

  assign qualified_o = r_qual;

endmodule

// File: rtl/pcie_rx_detect_ctrl.sv
// pcie_rx_detect_ctrl: receiver-detect and lane-qualification controller.
// Runs QUIET/CHARGE/SAMPLE with per-lane debounce, retries when no lane
// qualifies, then reports lane mask, link width and encoder enables.
// Optional build macro PCIE_RX_DETECT_LANE_REVERSAL_EN: when the normal
// width is 0, also try the lanes in reversed order and flag lane_reversed_o.
module pcie_rx_detect_ctrl
  import pcie_phys_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned QUIET_CYCLES  = 64,
  parameter int unsigned CHARGE_CYCLES = 4,
  parameter int unsigned DETECT_CYCLES = 16,
  parameter int unsigned RETRY_MAX     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [1:0]                     gen_i,
  input  logic [NUM_LANES-1:0]           load_detect_i,
  output logic                           rx_detect_en_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           detect_fail_o,
  output logic [NUM_LANES-1:0]           lane_mask_o,
  output logic [$clog2(NUM_LANES):0]     link_width_o,
  output logic                           lane_reversed_o,
  output logic                           en_8b10b_o,
  output logic                           en_128b130b_o
);

  localparam int unsigned LW         = $clog2(NUM_LANES) + 1;
  localparam int unsigned WIN_CYCLES = 2 * DETECT_CYCLES;
  localparam int unsigned QC_MAX     = (QUIET_CYCLES > CHARGE_CYCLES) ? QUIET_CYCLES : CHARGE_CYCLES;
  localparam int unsigned CNT_MAX    = (QC_MAX > WIN_CYCLES) ? QC_MAX : WIN_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W      = $clog2(RETRY_MAX + 2);

  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(WIN_CYCLES - 1);

  rx_detect_state_e     r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [RTY_W-1:0]     r_retry;
  link_gen_e            r_gen;
  logic                 r_rx_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic [NUM_LANES-1:0] r_mask;
  logic [LW-1:0]        r_width;
  logic                 r_en_8b10b;
  logic                 r_en_128b130b;

  logic [NUM_LANES-1:0]  w_qual;
  logic                  w_deb_clr;
  logic                  w_deb_en;
  logic                  w_all_qual;
  logic                  w_retry;
  logic [MAX_LANES-1:0]  w_mask16;
  logic [WIDTH_BITS-1:0] w_width_norm;
  logic [LW-1:0]         w_width_final;
  logic                  w_width_nz;

  // Debounce counters restart on the CHARGE->SAMPLE edge and only count in SAMPLE.
  assign w_deb_clr = (r_state == ST_CHARGE) && (r_cnt == CHARGE_LAST);
  assign w_deb_en  = (r_state == ST_SAMPLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pcie_lane_debounce #(
        .DETECT_CYCLES (DETECT_CYCLES)
      ) u_debounce (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clr_i         (w_deb_clr),
        .en_i          (w_deb_en),
        .load_detect_i (load_detect_i[gi]),
        .qualified_o   (w_qual[gi])
      );
    end
  endgenerate

  assign w_all_qual   = &w_qual;
  assign w_retry      = (w_qual == '0) && (r_retry < RTY_W'(RETRY_MAX));
  assign w_mask16     = MAX_LANES'(w_qual);
  assign w_width_norm = width_from_mask(w_mask16, NUM_LANES);

`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
  logic [NUM_LANES-1:0]  w_mask_rev;
  logic [WIDTH_BITS-1:0] w_width_rev;
  logic                  w_rev_sel;
  logic                  r_lane_reversed;

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_rev
      assign w_mask_rev[gi] = w_qual[NUM_LANES-1-gi];
    end
  endgenerate

  assign w_width_rev     = width_from_mask(MAX_LANES'(w_mask_rev), NUM_LANES);
  assign w_rev_sel       = (w_width_norm == '0) && (w_width_rev != '0);
  assign w_width_final   = w_rev_sel ? LW'(w_width_rev) : LW'(w_width_norm);
  assign lane_reversed_o = r_lane_reversed;
`else
  assign w_width_final   = LW'(w_width_norm);
  assign lane_reversed_o = 1'b0;
`endif

  assign w_width_nz = (w_width_final != '0);

  // Detect sequencer: phase timing, retry policy and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_gen         <= GEN1;
      r_rx_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_mask        <= '0;
      r_width       <= '0;
      r_en_8b10b    <= 1'b0;
      r_en_128b130b <= 1'b0;
`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
      r_lane_reversed <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state       <= ST_QUIET;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_gen         <= (gen_i == 2'd0) ? GEN1 : link_gen_e'(gen_i);
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_mask        <= '0;
            r_width       <= '0;
            r_en_8b10b    <= 1'b0;
            r_en_128b130b <= 1'b0;
`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
            r_lane_reversed <= 1'b0;
`endif
          end
        end
        ST_QUIET: begin
          if (r_cnt == QUIET_LAST) begin
            r_state <= ST_CHARGE;
            r_cnt   <= '0;
            r_rx_en <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CHARGE: begin
          if (r_cnt == CHARGE_LAST) begin
            r_state <= ST_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (w_all_qual || (r_cnt == WIN_LAST)) begin
            r_state <= ST_EVAL;
            r_cnt   <= '0;
            r_rx_en <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          r_mask <= w_qual;
          if (w_retry) begin
            r_state <= ST_QUIET;
            r_retry <= r_retry + RTY_W'(1);
          end else begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_width       <= w_width_final;
            r_fail        <= !w_width_nz;
            r_en_8b10b    <= w_width_nz && (r_gen != GEN3);
            r_en_128b130b <= w_width_nz && (r_gen == GEN3);
`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
            r_lane_reversed <= w_rev_sel;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_detect_en_o = r_rx_en;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign detect_fail_o  = r_fail;
  assign lane_mask_o    = r_mask;
  assign link_width_o   = r_width;
  assign en_8b10b_o     = r_en_8b10b;
  assign en_128b130b_o  = r_en_128b130b;

endmodule

// File: tb/tb_pcie_rx_detect_ctrl.sv
// tb_pcie_rx_detect_ctrl: table vectors, hand-written corner sequences and
// randomized lane patterns checked against a timeline model of detect.
module tb_pcie_rx_detect_ctrl;

  localparam int N      = 4;
  localparam int Q      = 64;
  localparam int C      = 4;
  localparam int D      = 16;
  localparam int R      = 2;
  localparam int BUDGET = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   gen_in = 2'd0;
  logic [N-1:0] load = '0;

  logic         rx_detect_en_o, busy_o, done_o, detect_fail_o;
  logic [N-1:0] lane_mask_o;
  logic [2:0]   link_width_o;
  logic         lane_reversed_o, en_8b10b_o, en_128b130b_o;

  pcie_rx_detect_ctrl #(
    .NUM_LANES(N), .QUIET_CYCLES(Q), .CHARGE_CYCLES(C), .DETECT_CYCLES(D), .RETRY_MAX(R)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .gen_i           (gen_in),
    .load_detect_i   (load),
    .rx_detect_en_o  (rx_detect_en_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .detect_fail_o   (detect_fail_o),
    .lane_mask_o     (lane_mask_o),
    .link_width_o    (link_width_o),
    .lane_reversed_o (lane_reversed_o),
    .en_8b10b_o      (en_8b10b_o),
    .en_128b130b_o   (en_128b130b_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Load pattern indexed by clock edge number, edge 0 being the start edge.
  logic [N-1:0] pat [0:BUDGET];

  typedef struct {
    int           done_edge;
    logic [N-1:0] mask;
    int           width;
    logic         fail;
    logic         en8;
    logic         en128;
    logic         rev;
    int           rx_cnt;
  } exp_t;

  typedef struct {
    logic [N-1:0] load;
    logic         tog2;
    logic [1:0]   gen;
    int           lat;
    logic [N-1:0] mask;
    int           width;
    logic         fail;
    logic         en8;
    logic         en128;
    logic         rev;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_all();
    return int'({rx_detect_en_o, busy_o, done_o, detect_fail_o, lane_mask_o,
                 link_width_o, lane_reversed_o, en_8b10b_o, en_128b130b_o});
  endfunction

  // Largest power-of-two prefix of set lanes.
  function automatic int width_ref(input logic [N-1:0] m);
    int w;
    bit all1;
    w = 0;
    for (int k = 1; k <= N; k = k * 2) begin
      all1 = 1'b1;
      for (int l = 0; l < k; l++) if (!m[l]) all1 = 1'b0;
      if (all1) w = k;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] rev_mask(input logic [N-1:0] m);
    logic [N-1:0] r;
    for (int l = 0; l < N; l++) r[l] = m[N-1-l];
    return r;
  endfunction

  // Timeline model: attempts of QUIET+CHARGE then a sample window; a lane is
  // qualified when its trailing run of high samples reaches D.
  function automatic exp_t model(input logic [1:0] g);
    exp_t x;
    int   e_start, base, n;
    int   run [N];
    bit   allq;
    x = '{default: 0};
    e_start = 0;
    for (int a = 0; a <= R; a++) begin
      base = e_start + Q + C;
      for (int l = 0; l < N; l++) run[l] = 0;
      n = 2 * D;
      for (int k = 1; k <= 2 * D; k++) begin
        allq = 1'b1;
        for (int l = 0; l < N; l++) if (run[l] < D) allq = 1'b0;
        for (int l = 0; l < N; l++) run[l] = pat[base + k][l] ? run[l] + 1 : 0;
        if (allq) begin
          n = k;
          break;
        end
      end
      for (int l = 0; l < N; l++) x.mask[l] = (run[l] >= D);
      x.rx_cnt += C + n;
      if (x.mask == '0 && a < R) begin
        e_start = base + n + 1;
      end else begin
        x.done_edge = base + n + 1;
        break;
      end
    end
    x.width = width_ref(x.mask);
    x.rev   = 1'b0;
`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
    if (x.width == 0 && width_ref(rev_mask(x.mask)) != 0) begin
      x.width = width_ref(rev_mask(x.mask));
      x.rev   = 1'b1;
    end
`endif
    x.fail  = (x.width == 0);
    x.en8   = (x.width != 0) && (g != 2'd3);
    x.en128 = (x.width != 0) && (g == 2'd3);
    return x;
  endfunction

  // Issue a start, replay pat edge by edge until done_o; optional extra start
  // pulse sampled at edge start_again_edge+1.
  task automatic run_detect(input logic [1:0] g, input int start_again_edge,
                            output int done_edge, output int rx_cnt, output int busy_cnt);
    done_edge = -1;
    rx_cnt    = 0;
    busy_cnt  = 0;
    @(negedge clk);
    load   = pat[0];
    gen_in = g;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < BUDGET; e++) begin
      if (done_o) begin
        done_edge = e;
        break;
      end
      rx_cnt   += int'(rx_detect_en_o);
      busy_cnt += int'(busy_o);
      start = (e == start_again_edge);
      load  = pat[e + 1];
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic fill_const(input logic [N-1:0] v);
    for (int t = 0; t <= BUDGET; t++) pat[t] = v;
  endtask

  vec_t tbl [8];
  exp_t x;
  int   de, rxc, bc;

  initial begin
    tbl[0] = '{4'b1111, 1'b0, 2'd2,  86, 4'b1111, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'b0111, 1'b0, 2'd3, 101, 4'b0111, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'b0000, 1'b0, 2'd1, 303, 4'b0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 1'b1, 2'd1, 101, 4'b1011, 2, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef PCIE_RX_DETECT_LANE_REVERSAL_EN
    tbl[4] = '{4'b1100, 1'b0, 2'd2, 101, 4'b1100, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{4'b1110, 1'b0, 2'd3, 101, 4'b1110, 2, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    tbl[4] = '{4'b1100, 1'b0, 2'd2, 101, 4'b1100, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{4'b1110, 1'b0, 2'd3, 101, 4'b1110, 0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    tbl[5] = '{4'b1111, 1'b0, 2'd0,  86, 4'b1111, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'b0001, 1'b0, 2'd3, 101, 4'b0001, 1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_all(), 0);
    $display("reset: outputs=%h", outs_all());
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t <= BUDGET; t++) begin
        pat[t] = tbl[i].load;
        if (tbl[i].tog2) pat[t][2] = ((t / 4) % 2 == 0);
      end
      x = model(tbl[i].gen);
      run_detect(tbl[i].gen, -1, de, rxc, bc);
      $display("vec %0d: load=%b gen=%0d done@%0d mask=%b width=%0d fail=%b en8=%b en128=%b rev=%b",
               i, tbl[i].load, tbl[i].gen, de, lane_mask_o, link_width_o, detect_fail_o,
               en_8b10b_o, en_128b130b_o, lane_reversed_o);
      check($sformatf("vec%0d_latency", i), de, tbl[i].lat);
      check($sformatf("vec%0d_mask", i), int'(lane_mask_o), int'(tbl[i].mask));
      check($sformatf("vec%0d_width", i), int'(link_width_o), tbl[i].width);
      check($sformatf("vec%0d_fail", i), int'(detect_fail_o), int'(tbl[i].fail));
      check($sformatf("vec%0d_en8b10b", i), int'(en_8b10b_o), int'(tbl[i].en8));
      check($sformatf("vec%0d_en128b130b", i), int'(en_128b130b_o), int'(tbl[i].en128));
      check($sformatf("vec%0d_reversed", i), int'(lane_reversed_o), int'(tbl[i].rev));
      check($sformatf("vec%0d_busy_cycles", i), bc, tbl[i].lat);
      check($sformatf("vec%0d_rx_en_cycles", i), rxc, x.rx_cnt);
      check($sformatf("vec%0d_busy_in_done", i), int'(busy_o), 0);
    end

    // Start pulse while busy in QUIET is ignored
    fill_const(4'b1111);
    run_detect(2'd2, 30, de, rxc, bc);
    $display("seq start_in_quiet: done@%0d", de);
    check("start_in_quiet_latency", de, 86);

    // Start coinciding with EVAL->DONE is ignored; results then hold
    run_detect(2'd2, 85, de, rxc, bc);
    $display("seq start_at_eval: done@%0d", de);
    check("start_at_eval_latency", de, 86);
    repeat (3) @(negedge clk);
    check("start_at_eval_done_held", int'(done_o), 1);
    check("start_at_eval_not_busy", int'(busy_o), 0);
    load = '0;
    repeat (20) @(negedge clk);
    $display("seq hold: mask=%b width=%0d done=%b", lane_mask_o, link_width_o, done_o);
    check("hold_mask", int'(lane_mask_o), 15);
    check("hold_width", int'(link_width_o), 4);
    check("hold_en8b10b", int'(en_8b10b_o), 1);

    // Reset while in DONE clears every output immediately
    rst_n = 1'b0;
    #1;
    $display("seq reset_in_done: outputs=%h", outs_all());
    check("reset_in_done", outs_all(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset 10 cycles into SAMPLE, then a fresh start completes normally
    fill_const(4'b1111);
    @(negedge clk);
    load   = 4'b1111;
    gen_in = 2'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (Q + C + 10) @(negedge clk);
    check("mid_sample_rx_en", int'(rx_detect_en_o), 1);
    check("mid_sample_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    $display("seq reset_mid_sample: outputs=%h", outs_all());
    check("reset_mid_sample", outs_all(), 0);
    @(negedge clk);
    check("reset_held", outs_all(), 0);
    rst_n = 1'b1;
    run_detect(2'd3, -1, de, rxc, bc);
    $display("seq after_reset: done@%0d mask=%b", de, lane_mask_o);
    check("after_reset_latency", de, 86);
    check("after_reset_mask", int'(lane_mask_o), 15);
    check("after_reset_en128b130b", int'(en_128b130b_o), 1);

    // Randomized lane behaviour against the timeline model
    for (int it = 0; it < 25; it++) begin
      logic [1:0] g;
      int mode, p1, p2;
      g = 2'($urandom_range(0, 3));
      for (int l = 0; l < N; l++) begin
        mode = (it % 4 == 3) ? 9 : int'($urandom_range(0, 9));
        p1   = int'($urandom_range(60, 260));
        p2   = int'($urandom_range(1, 12));
        for (int t = 0; t <= BUDGET; t++) begin
          case (mode)
            0, 1, 2, 3: pat[t][l] = 1'b1;
            4:          pat[t][l] = 1'b0;
            5, 6:       pat[t][l] = !(t >= p1 && t < p1 + (p2 % 3) + 1);
            7:          pat[t][l] = ((t / p2) % 2 == 0);
            8:          pat[t][l] = 1'($urandom_range(0, 1));
            default:    pat[t][l] = (t >= p1);
          endcase
        end
      end
      x = model(g);
      run_detect(g, -1, de, rxc, bc);
      $display("rnd %0d: gen=%0d done@%0d (exp %0d) mask=%b (exp %b) width=%0d (exp %0d)",
               it, g, de, x.done_edge, lane_mask_o, x.mask, link_width_o, x.width);
      check($sformatf("rnd%0d_latency", it), de, x.done_edge);
      check($sformatf("rnd%0d_mask", it), int'(lane_mask_o), int'(x.mask));
      check($sformatf("rnd%0d_width", it), int'(link_width_o), x.width);
      check($sformatf("rnd%0d_fail", it), int'(detect_fail_o), int'(x.fail));
      check($sformatf("rnd%0d_en8b10b", it), int'(en_8b10b_o), int'(x.en8));
      check($sformatf("rnd%0d_en128b130b", it), int'(en_128b130b_o), int'(x.en128));
      check($sformatf("rnd%0d_reversed", it), int'(lane_reversed_o), int'(x.rev));
      check($sformatf("rnd%0d_rx_en_cycles", it), rxc, x.rx_cnt);
      check($sformatf("rnd%0d_busy_cycles", it), bc, x.done_edge);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
